data_mem_ctrl: RTL and testbench

Parametrised byte-addressed data memory with a request/done handshake, programmable wait states, and byte/halfword/word access with sign or zero extension on loads. It sits behind the CPU load/store unit and replaces the single-cycle word-addressed data memory. Misaligned and illegal-size accesses are flagged and never corrupt memory.

---
 rtl/data_mem_ctrl.sv | 178 +++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Byte-addressed 32-bit data memory with req/done handshake, programmable wait states,
// byte/half/word access with load extension and misalignment flagging.
module data_mem_ctrl #(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        uns,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        err
);

   localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
   localparam int unsigned CNT_W     = 4;
   localparam int unsigned AW        = ADDR_WIDTH + 2;
   localparam int unsigned WAIT_LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_ACCESS = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               accept_c;

   logic               we_q;
   logic [1:0]         size_q;
   logic               uns_q;
   logic [AW-1:0]      addr_q;
   logic [31:0]        wdata_q;

   logic               busy_q, done_q, err_q;
   logic [31:0]        rdata_q;

   logic [31:0]        mem [DEPTH];

   logic [ADDR_WIDTH-1:0] idx_c;
   logic [1:0]         off_c;
   logic               mis_c;
   logic [31:0]        rword_c;
   logic [7:0]         rbyte_c;
   logic [15:0]        rhalf_c;
   logic [31:0]        load_c;
   logic [31:0]        wlane_c;
   logic [3:0]         be_c;
   logic               addr_unused_c;

   // Upper address bits are don't-care: addresses wrap modulo the memory size.
   assign addr_unused_c = ^addr[31:AW];

   // Next-state logic.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      accept_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               accept_c = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  state_d = S_ACCESS;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_W'(WAIT_LOAD);
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               state_d = S_ACCESS;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_ACCESS: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Address decode, alignment check, load extraction and store lane steering.
   always_comb begin
      idx_c   = addr_q[AW-1:2];
      off_c   = addr_q[1:0];
      mis_c   = (size_q == 2'b11) ||
                ((size_q == 2'b01) && addr_q[0]) ||
                ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
      rword_c = mem[idx_c];
      rbyte_c = rword_c[{off_c, 3'b000} +: 8];
      rhalf_c = rword_c[{off_c[1], 4'b0000} +: 16];
      load_c  = '0;
      wlane_c = wdata_q;
      be_c    = 4'b0000;
      case (size_q)
         2'b00: begin
            load_c  = uns_q ? {24'h0, rbyte_c} : {{24{rbyte_c[7]}}, rbyte_c};
            wlane_c = {4{wdata_q[7:0]}};
            be_c    = 4'(4'b0001 << off_c);
         end
         2'b01: begin
            load_c  = uns_q ? {16'h0, rhalf_c} : {{16{rhalf_c[15]}}, rhalf_c};
            wlane_c = {2{wdata_q[15:0]}};
            be_c    = off_c[1] ? 4'b1100 : 4'b0011;
         end
         2'b10: begin
            load_c  = rword_c;
            be_c    = 4'b1111;
         end
         default: begin
            load_c  = '0;
            be_c    = 4'b0000;
         end
      endcase
   end

   // Byte-enabled store on the edge that ends ACCESS; array is not reset.
   always_ff @(posedge clk) begin
      if ((state_q == S_ACCESS) && we_q && !mis_c) begin
         for (int i = 0; i < 4; i++) begin
            if (be_c[i]) begin
               mem[idx_c][8*i +: 8] <= wlane_c[8*i +: 8];
            end
         end
      end
   end

   // State, latched request and registered outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= (state_d != S_IDLE);
         done_q  <= (state_q == S_ACCESS);
         if (accept_c) begin
            we_q    <= we;
            size_q  <= size;
            uns_q   <= uns;
            addr_q  <= addr[AW-1:0];
            wdata_q <= wdata;
         end
         if (state_q == S_ACCESS) begin
            err_q <= mis_c;
            if (mis_c) begin
               rdata_q <= '0;
            end else if (!we_q) begin
               rdata_q <= load_c;
            end
         end
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign rdata = rdata_q;
   assign err   = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: one instance without wait states, one with three.
module tb_data_mem_ctrl;

   logic        clk = 1'b0;
   logic        rstn;
   logic        req0, req3;
   logic        we;
   logic [1:0]  size;
   logic        uns;
   logic [31:0] addr, wdata;
   logic        busy0, done0, err0;
   logic        busy3, done3, err3;
   logic [31:0] rdata0, rdata3;

   int tests  = 0;
   int failed = 0;

   always #5 clk = ~clk;

   data_mem_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u0 (
      .clk(clk), .rstn(rstn), .req(req0), .we(we), .size(size), .uns(uns),
      .addr(addr), .wdata(wdata), .busy(busy0), .done(done0), .rdata(rdata0), .err(err0)
   );

   data_mem_ctrl #(.ADDR_WIDTH(10), .WAIT_CYCLES(3)) u3 (
      .clk(clk), .rstn(rstn), .req(req3), .we(we), .size(size), .uns(uns),
      .addr(addr), .wdata(wdata), .busy(busy3), .done(done3), .rdata(rdata3), .err(err3)
   );

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic        chk_rd;
   } vec_t;

   localparam int NVEC = 17;
   vec_t vecs [NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One complete access; m counts negedges after the accept edge until done.
   task automatic access(input bit sel, input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int m);
      @(negedge clk);
      we = w; size = sz; uns = u; addr = a; wdata = wd;
      if (sel) req3 = 1'b1; else req0 = 1'b1;
      @(negedge clk);
      req0 = 1'b0; req3 = 1'b0;
      m = 0;
      while (!(sel ? done3 : done0) && m < 40) begin
         @(negedge clk);
         m++;
      end
      rd = sel ? rdata3 : rdata0;
      er = sel ? err3 : err0;
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          m;
      int          dcount;

      vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h8899AABB, 32'h0000_0000, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        32'h8899AABB, 1'b0, 1'b1};
      vecs[2]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h0000_007F, 32'h0,       1'b0, 1'b0};
      vecs[3]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0012, 32'h0000_F00D, 32'h0,       1'b0, 1'b0};
      vecs[4]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        32'hF00D7FBB, 1'b0, 1'b1};
      vecs[5]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0012, 32'h0,        32'h0000000D, 1'b0, 1'b1};
      vecs[6]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0,        32'hFFFFF00D, 1'b0, 1'b1};
      vecs[7]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0,        32'h0000F00D, 1'b0, 1'b1};
      vecs[8]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0013, 32'h12345678, 32'h0,        1'b1, 1'b1};
      vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        32'hF00D7FBB, 1'b0, 1'b1};
      vecs[10] = '{1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,        32'h0,        1'b1, 1'b1};
      vecs[11] = '{1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0,        32'hFFFFFFF0, 1'b0, 1'b1};
      vecs[12] = '{1'b0, 2'b00, 1'b1, 32'h0000_0011, 32'h0,        32'h0000007F, 1'b0, 1'b1};
      vecs[13] = '{1'b0, 2'b01, 1'b0, 32'h0000_0011, 32'h0,        32'h0,        1'b1, 1'b1};
      vecs[14] = '{1'b1, 2'b10, 1'b0, 32'h0000_1000, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0};
      vecs[15] = '{1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0,        32'hCAFEF00D, 1'b0, 1'b1};
      vecs[16] = '{1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0,        32'hFFFFFFCA, 1'b0, 1'b1};

      rstn = 1'b0; req0 = 1'b0; req3 = 1'b0;
      we = 1'b0; size = 2'b00; uns = 1'b0; addr = '0; wdata = '0;
      repeat (3) @(negedge clk);
      chk("reset_u0", {busy0, done0, err0, rdata0[28:0]}, 32'h0);
      chk("reset_u3", {busy3, done3, err3, rdata3[28:0]}, 32'h0);
      chk("reset_rdata_hi", {26'h0, rdata0[31:29], rdata3[31:29]}, 32'h0);
      rstn = 1'b1;

      // Zero-wait-state table: stores, loads, extension, misalignment, wrap.
      for (int i = 0; i < NVEC; i++) begin
         access(1'b0, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                rd, er, m);
         chk($sformatf("vec%0d_latency", i), 32'(m), 32'd1);
         chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
         if (vecs[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      end

      // Three wait states: seed 0x20.
      access(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11111111, rd, er, m);
      chk("w3_store_latency", 32'(m), 32'd4);
      chk("w3_store_err", 32'(er), 32'd0);

      // Busy window and ignored req pulses during a wait-state load.
      @(negedge clk);
      we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h20; req3 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("w3_busy_m%0d", k), {30'h0, busy3, done3}, 32'h2);
         req3 = (k % 2 == 0) ? 1'b1 : 1'b0;
      end
      @(negedge clk);
      chk("w3_done_busy", {30'h0, busy3, done3}, 32'h1);
      chk("w3_load_rdata", rdata3, 32'h11111111);
      chk("w3_load_err", 32'(err3), 32'd0);
      dcount = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (done3 || busy3) dcount++;
      end
      chk("w3_no_extra_access", 32'(dcount), 32'd0);

      // Reset during WAIT of a store aborts it without writing.
      @(negedge clk);
      we = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'h22222222; req3 = 1'b1;
      @(negedge clk);
      req3 = 1'b0;
      @(negedge clk);
      chk("w3_in_wait", 32'(busy3), 32'd1);
      #2 rstn = 1'b0;
      #1;
      chk("abort_outputs", {29'h0, busy3, done3, err3}, 32'h0);
      chk("abort_rdata", rdata3, 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      access(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, m);
      chk("abort_latency", 32'(m), 32'd4);
      chk("abort_no_write", rd, 32'h11111111);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
